axi_lite_clint_slave: RTL and testbench
=======================================

// Module: axi_lite_clint_slave
// PURPOSE
//  AXI4-Lite responder exposing a RISC-V CLINT (msip, mtimecmp, mtime) as 32-bit registers.
//  Sits on the peripheral interconnect and answers the core's peripheral master.
//  Drives MTIP/MSIP interrupt lines into the core.
// PARAMETERS
//  ADDR_WIDTH   16  byte-address bits decoded (offset within CLINT window)
//  TICK_DIV     1   S_AXI_ACLK cycles per mtime increment (>=1)
// PORTS
//  S_AXI_ACLK     in   1   clock; single clock domain
//  S_AXI_ARESET   in   1   reset, asynchronous, active-high
//  S_AXI_AWADDR   in   ADDR_WIDTH  write address
//  S_AXI_AWPROT   in   3   ignored
//  S_AXI_AWVALID  in   1   / S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   32  / S_AXI_WSTRB in 4 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1
//  S_AXI_BRESP    out  2   / S_AXI_BVALID out 1 / S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   ADDR_WIDTH  / S_AXI_ARPROT in 3 (ignored)
//  S_AXI_ARVALID  in   1   / S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  32  / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1
//  MTIP           out  1   timer interrupt, registered (mtime >= mtimecmp)
//  MSIP           out  1   software interrupt = msip[0]
// BEHAVIOUR
//  Map (ADDR[1:0] ignored): 0x0000 msip (bit0 only, rest RAZ/WI); 0x4000/0x4004 mtimecmp lo/hi;
//   0xBFF8/0xBFFC mtime lo/hi. Anything else is unmapped.
//  Reset: all outputs 0 except AWREADY=WREADY=ARREADY=1; mtime=0, mtimecmp=all ones,
//   msip=0, prescaler=0. Reset mid-transaction drops it; no B/R beat issued.
//  Write FSM W_IDLE/W_RESP: in W_IDLE AWREADY stays high until AW captured, WREADY until
//   W captured (either order, or same cycle). Cycle after both captured: register updated
//   with WSTRB byte lanes, BVALID=1, BRESP=OKAY, go W_RESP, AWREADY=WREADY=0.
//   W_RESP: hold BVALID/BRESP until BREADY; then BVALID=0, READYs=1, back to W_IDLE.
//  Read FSM R_IDLE/R_DATA: ARREADY=1 in R_IDLE; on AR handshake, next cycle RVALID=1 with
//   RDATA sampled at handshake cycle, ARREADY=0. Hold RDATA/RRESP/RVALID until RREADY.
//  Read and write channels independent; both may complete in same cycle.
//  mtime: prescaler counts 0..TICK_DIV-1; mtime+=1 when it wraps; 64-bit wrap to 0.
//   A write to mtime lo/hi in same cycle as an increment: written bytes take write value,
//   other half keeps its pre-increment value (no carry applied that cycle).
//  Read of mtime lo/hi returns current register value; no latching of the other half.
//  MTIP registered from unsigned 64-bit compare; updates one cycle after mtime/mtimecmp change.
// CONFIGURATION
//  CLINT_SLVERR_EN defined: unmapped read -> RRESP=2'b10, RDATA=0; unmapped write ->
//   BRESP=2'b10, no state change. Not defined: unmapped accesses get OKAY, RDATA=0, writes dropped.
//  Timing of handshakes identical in both builds.
// TESTING
//  Reset -> MTIP=0, MSIP=0, read 0x4000 and 0x4004 both 0xFFFFFFFF, RRESP=0.
//  AW at cycle 0, W at cycle 3 to 0x0000 data 1 -> BVALID cycle 4, MSIP=1; BREADY low 5 cycles -> BVALID held.
//  Write mtimecmp hi=0, lo=20, TICK_DIV=1 -> MTIP rises when mtime reaches 20, one cycle later.
//  Write 0xBFF8 data 0xFFFFFFFF WSTRB=4'b0011 -> mtime lo becomes 0x0000FFFF then counts.
//  Read 0x1234 -> RDATA=0; RRESP=2'b10 with CLINT_SLVERR_EN, 2'b00 without.
//  Simultaneous AR (0xBFF8) and AW+W (0x0000): both responses issued next cycle, correct data.

Source files
------------

// File: rtl/axi_lite_clint_slave.sv
// ============================================================================
// Module   : axi_lite_clint_slave
// Purpose  : AXI4-Lite responder for a RISC-V CLINT (msip, mtimecmp, mtime).
// Options  : define CLINT_SLVERR_EN to answer unmapped accesses with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axi_lite_clint_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int TICK_DIV   = 1
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  MTIP,
  output logic                  MSIP
);

  localparam int                    PS_W          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]       C_PS_LAST     = PS_W'(TICK_DIV - 1);
  localparam logic [1:0]            C_RESP_OKAY   = 2'b00;
  localparam logic [1:0]            C_RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] C_A_MSIP      = ADDR_WIDTH'(16'h0000);
  localparam logic [ADDR_WIDTH-1:0] C_A_CMP_LO    = ADDR_WIDTH'(16'h4000);
  localparam logic [ADDR_WIDTH-1:0] C_A_CMP_HI    = ADDR_WIDTH'(16'h4004);
  localparam logic [ADDR_WIDTH-1:0] C_A_TIME_LO   = ADDR_WIDTH'(16'hBFF8);
  localparam logic [ADDR_WIDTH-1:0] C_A_TIME_HI   = ADDR_WIDTH'(16'hBFFC);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;
  typedef enum logic [2:0] {
    SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_TIME_LO, SEL_TIME_HI
  } sel_e;

  function automatic sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] word;
    word = {a[ADDR_WIDTH-1:2], 2'b00};
    case (word)
      C_A_MSIP:    decode = SEL_MSIP;
      C_A_CMP_LO:  decode = SEL_CMP_LO;
      C_A_CMP_HI:  decode = SEL_CMP_HI;
      C_A_TIME_LO: decode = SEL_TIME_LO;
      C_A_TIME_HI: decode = SEL_TIME_HI;
      default:     decode = SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  wstate_e               w_state_q, w_state_d;
  rstate_e               r_state_q, r_state_d;
  logic                  aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  msip_q, msip_d, mtip_q, mtip_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d, mtime_q, mtime_d;
  logic [PS_W-1:0]       prescaler_q, prescaler_d;

  logic                  tick, aw_hs, w_hs, do_write;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  unused_prot;

  assign unused_prot   = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_have_q;
  assign S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_have_q;
  assign S_AXI_ARREADY = (r_state_q == R_IDLE);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign MSIP          = msip_q;
  assign MTIP          = mtip_q;

  always_comb begin
    w_state_d   = w_state_q;
    r_state_d   = r_state_q;
    aw_have_d   = aw_have_q;
    w_have_d    = w_have_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    do_write    = 1'b0;

    tick        = (prescaler_q == C_PS_LAST);
    prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtip_d      = (mtime_q >= mtimecmp_q);

    aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    wr_addr = aw_have_q ? awaddr_q : S_AXI_AWADDR;
    wr_data = w_have_q ? wdata_q : S_AXI_WDATA;
    wr_strb = w_have_q ? wstrb_q : S_AXI_WSTRB;

    case (w_state_q)
      W_IDLE: begin
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          do_write  = 1'b1;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = C_RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_have_d = 1'b1;
            awaddr_d  = S_AXI_AWADDR;
          end
          if (w_hs) begin
            w_have_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    // A write to one mtime half overrides that cycle's increment entirely.
    if (do_write) begin
      case (decode(wr_addr))
        SEL_MSIP:    msip_d = wr_strb[0] ? wr_data[0] : msip_q;
        SEL_CMP_LO:  mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wr_data, wr_strb);
        SEL_CMP_HI:  mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wr_data, wr_strb);
        SEL_TIME_LO: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wr_data, wr_strb)};
        SEL_TIME_HI: mtime_d = {merge(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
        default: begin
`ifdef CLINT_SLVERR_EN
          bresp_d = C_RESP_SLVERR;
`endif
        end
      endcase
    end

    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          rvalid_d  = 1'b1;
          rresp_d   = C_RESP_OKAY;
          r_state_d = R_DATA;
          case (decode(S_AXI_ARADDR))
            SEL_MSIP:    rdata_d = {31'd0, msip_q};
            SEL_CMP_LO:  rdata_d = mtimecmp_q[31:0];
            SEL_CMP_HI:  rdata_d = mtimecmp_q[63:32];
            SEL_TIME_LO: rdata_d = mtime_q[31:0];
            SEL_TIME_HI: rdata_d = mtime_q[63:32];
            default: begin
              rdata_d = 32'd0;
`ifdef CLINT_SLVERR_EN
              rresp_d = C_RESP_SLVERR;
`endif
            end
          endcase
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      aw_have_q   <= 1'b0;
      w_have_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      bvalid_q    <= 1'b0;
      bresp_q     <= C_RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= C_RESP_OKAY;
      rdata_q     <= 32'd0;
      msip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      mtimecmp_q  <= '1;
      mtime_q     <= 64'd0;
      prescaler_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      aw_have_q   <= aw_have_d;
      w_have_q    <= w_have_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      mtimecmp_q  <= mtimecmp_d;
      mtime_q     <= mtime_d;
      prescaler_q <= prescaler_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_clint_slave.sv
// ============================================================================
// Module   : tb_axi_lite_clint_slave
// Purpose  : Directed self-checking bench for axi_lite_clint_slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_lite_clint_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, mtip, msip;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_hs_cyc, rd_hs_cyc;

`ifdef CLINT_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_clint_slave #(.ADDR_WIDTH(16), .TICK_DIV(1)) dut (
    .S_AXI_ACLK(clk),       .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),   .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),   .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready),
    .MTIP(mtip),            .MSIP(msip)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left 1ns after a rising edge.
  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_seen = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
    end
    wr_hs_cyc = cyc;
    if (!(aw_done && w_done)) check_val("wr_hs_timeout", {63'd0, aw_done && w_done}, 64'd1);
    for (int i = 0; i < 20 && !b_seen; i++) begin
      @(negedge clk);
      b_seen = bvalid;
    end
    if (!b_seen) check_val("bvalid_timeout", {63'd0, b_seen}, 64'd1);
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_done = 0, r_seen = 0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20 && !ar_done; i++) begin
      @(negedge clk);
      if (arready) ar_done = 1;
      @(posedge clk); #1;
      if (ar_done) arvalid = 1'b0;
    end
    rd_hs_cyc = cyc;
    if (!ar_done) check_val("ar_hs_timeout", {63'd0, ar_done}, 64'd1);
    for (int i = 0; i < 20 && !r_seen; i++) begin
      @(negedge clk);
      r_seen = rvalid;
    end
    if (!r_seen) check_val("rvalid_timeout", {63'd0, r_seen}, 64'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [63:0] exp64;
    int          t0, h_carry;
    bit          found;

    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_irq",    {62'd0, mtip, msip}, 64'd0);
    check_val("rst_ready",  {61'd0, awready, wready, arready}, 64'h7);
    check_val("rst_valid",  {62'd0, bvalid, rvalid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    axi_read(16'h4000, d, r);
    check_val("cmp_lo_rst", {30'd0, r, d}, 64'h0000_0000_FFFF_FFFF);
    axi_read(16'h4004, d, r);
    check_val("cmp_hi_rst", {30'd0, r, d}, 64'h0000_0000_FFFF_FFFF);

    // AW in cycle 0, W in cycle 3, response in cycle 4
    awaddr = 16'h0000; awvalid = 1'b1; wdata = 32'd1; wstrb = 4'hF;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check_val("split_ready_c1", {62'd0, awready, wready}, 64'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wvalid = 1'b1;
    @(negedge clk);
    check_val("split_bvalid_c3", {63'd0, bvalid}, 64'd0);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    check_val("split_c4", {59'd0, bvalid, bresp, msip, awready}, 64'b10010);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("bvalid_hold", {63'd0, bvalid}, 64'd1);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check_val("b_done", {61'd0, bvalid, awready, wready}, 64'b011);
    @(posedge clk); #1;

    axi_read(16'h0000, d, r);
    check_val("msip_rd1", {30'd0, r, d}, 64'd1);
    axi_write(16'h0000, 32'hFFFF_FFFE, 4'hF, r);
    check_val("msip_clr", {61'd0, r, msip}, 64'd0);
    axi_read(16'h0000, d, r);
    check_val("msip_raz", {30'd0, r, d}, 64'd0);

    // mtime cleared at edge t0, reaches 20 at t0+20, MTIP follows at t0+21
    axi_write(16'h4000, 32'd20, 4'hF, r);
    axi_write(16'hBFF8, 32'd0, 4'hF, r);
    t0 = wr_hs_cyc;
    axi_write(16'h4004, 32'd0, 4'hF, r);
    check_val("mtip_low_early", {63'd0, mtip}, 64'd0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = mtip;
    end
    check_val("mtip_rise_seen", {63'd0, found}, 64'd1);
    check_val("mtip_rise_cyc", 64'(cyc - t0), 64'd21);
    @(posedge clk); #1;

    axi_write(16'hBFF8, 32'hFFFF_FFFF, 4'b0011, r);
    t0 = wr_hs_cyc;
    axi_read(16'hBFF8, d, r);
    check_val("mtime_lo_strb", {32'd0, d}, 64'h0000_FFFF + 64'(rd_hs_cyc - 1 - t0));
    axi_read(16'hBFFC, d, r);
    check_val("mtime_hi_zero", {32'd0, d}, 64'd0);
    check_val("mtip_held", {63'd0, mtip}, 64'd1);

    axi_write(16'hBFF8, 32'hFFFF_FFF0, 4'hF, r);
    h_carry = wr_hs_cyc;
    repeat (30) @(posedge clk);
    #1;
    axi_read(16'hBFF8, d, r);
    exp64 = 64'hFFFF_FFF0 + 64'(rd_hs_cyc - 1 - h_carry);
    check_val("mtime_lo_wrap", {32'd0, d}, {32'd0, exp64[31:0]});
    axi_read(16'hBFFC, d, r);
    exp64 = 64'hFFFF_FFF0 + 64'(rd_hs_cyc - 1 - h_carry);
    check_val("mtime_hi_carry", {32'd0, d}, {32'd0, exp64[63:32]});

    axi_write(16'h4004, 32'hAABB_CCDD, 4'b0100, r);
    axi_read(16'h4004, d, r);
    check_val("cmp_hi_strb", {30'd0, r, d}, 64'h00BB_0000);
    check_val("mtip_fall", {63'd0, mtip}, 64'd0);

    axi_read(16'h1234, d, r);
    check_val("unmapped_rd", {30'd0, r, d}, {30'd0, EXP_ERR, 32'd0});
    axi_write(16'h2000, 32'd1, 4'hF, r);
    check_val("unmapped_wr", {62'd0, r}, {62'd0, EXP_ERR});
    check_val("unmapped_nochg", {63'd0, msip}, 64'd0);

    // Read and write handshakes in the same cycle
    araddr = 16'hBFF8; arvalid = 1'b1;
    awaddr = 16'h0000; awvalid = 1'b1; wdata = 32'd1; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check_val("simul_ready", {61'd0, awready, wready, arready}, 64'h7);
    @(posedge clk); #1;
    t0 = cyc;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check_val("simul_valid", {60'd0, rvalid, bvalid, msip, 1'b0}, 64'b1110);
    exp64 = 64'hFFFF_FFF0 + 64'(t0 - 1 - h_carry);
    check_val("simul_rdata", {28'd0, rresp, bresp, rdata}, {32'd0, exp64[31:0]});
    @(posedge clk); #1;
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    @(negedge clk);
    check_val("simul_done", {62'd0, rvalid, bvalid}, 64'd0);

    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst2", {61'd0, msip, mtip, bvalid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
